// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: a loadable instruction memory with a fetch engine.
// The engine streams words out with a one-cycle read latency, takes absolute or
// pc-relative branches with a single bubble, and stops when it retires HALT_INSTR.
module instr_fetch_unit #(
    parameter int unsigned          PC_W       = 8,
    parameter int unsigned          INSTR_W    = 9,
    parameter logic [INSTR_W-1:0]   HALT_INSTR = {INSTR_W{1'b1}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               load_en,
    input  logic [PC_W-1:0]    load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               stall,
    input  logic               branch_en,
    input  logic               branch_rel,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic               halted
);

    localparam int unsigned Depth = 2 ** PC_W;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalt
    } state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    fpc_q, fpc_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               halted_q, halted_d;

    // Instruction store; deliberately outside the reset domain so a reset
    // keeps the loaded program intact.
    logic [INSTR_W-1:0] mem_q [Depth];

    logic               mem_we;
    logic [INSTR_W-1:0] rd_data;
    logic [PC_W-1:0]    branch_dest;
    logic               halt_seen;
    logic               branch_take;

    // Loads are only accepted while the engine is not fetching; reset wins.
    assign mem_we      = load_en && !reset && (state_q != StRun);
    assign rd_data     = mem_q[fpc_q];
    // Same-width add wraps naturally, which is the sign-extended offset case.
    assign branch_dest = branch_rel ? pc_q + branch_target : branch_target;
    // A retiring halt outranks any branch offered in the same cycle.
    assign halt_seen   = valid_q && (instr_q == HALT_INSTR);
    assign branch_take = valid_q && branch_en && !halt_seen;

    // Memory write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // Next-state and datapath updates; stall freezes everything but loads.
    always_comb begin
        state_d  = state_q;
        fpc_d    = fpc_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        halted_d = halted_q;

        if (!stall) begin
            unique case (state_q)
                StIdle, StHalt: begin
                    valid_d = 1'b0;
                    if (start) begin
                        state_d  = StRun;
                        fpc_d    = '0;
                        halted_d = 1'b0;
                    end
                end
                StRun: begin
                    if (halt_seen) begin
                        state_d  = StHalt;
                        halted_d = 1'b1;
                        valid_d  = 1'b0;
                    end else if (branch_take) begin
                        // Bubble: the redirected word arrives one cycle later.
                        fpc_d   = branch_dest;
                        valid_d = 1'b0;
                    end else begin
                        instr_d = rd_data;
                        pc_d    = fpc_q;
                        valid_d = 1'b1;
                        fpc_d   = fpc_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            fpc_q    <= '0;
            pc_q     <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by
// random stimulus, all checked cycle by cycle against a behavioural model.
module tb_instr_fetch_unit;

    logic       clk;
    logic       reset;
    logic       start;
    logic       load_en;
    logic [7:0] load_addr;
    logic [8:0] load_data;
    logic       stall;
    logic       branch_en;
    logic       branch_rel;
    logic [7:0] branch_target;
    logic [7:0] pc;
    logic [8:0] instr;
    logic       instr_valid;
    logic       halted;

    instr_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .stall         (stall),
        .branch_en     (branch_en),
        .branch_rel    (branch_rel),
        .branch_target (branch_target),
        .pc            (pc),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: mode 0 idle, 1 running, 2 halted.
    localparam logic [8:0] Halt = 9'h1FF;
    logic [8:0] ref_mem [256];
    int         m_mode;
    logic [7:0] m_fpc;
    logic [7:0] m_pc;
    logic [8:0] m_instr;
    logic       m_valid;
    logic       m_halted;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        if (reset) begin
            m_mode = 0; m_fpc = 0; m_pc = 0; m_instr = 0; m_valid = 0; m_halted = 0;
        end else begin
            if (load_en && m_mode != 1) ref_mem[load_addr] = load_data;
            if (!stall) begin
                if (m_mode != 1) begin
                    if (start) begin
                        m_mode = 1; m_fpc = 0; m_halted = 0;
                    end
                end else if (m_valid && m_instr == Halt) begin
                    m_mode = 2; m_halted = 1; m_valid = 0;
                end else if (m_valid && branch_en) begin
                    if (branch_rel) m_fpc = m_pc + branch_target;
                    else            m_fpc = branch_target;
                    m_valid = 0;
                end else begin
                    m_instr = ref_mem[m_fpc];
                    m_pc    = m_fpc;
                    m_valid = 1;
                    m_fpc   = m_fpc + 8'd1;
                end
            end
        end
    endtask

    // One clock: model advances on the edge, outputs compared mid-cycle.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check("pc", 32'(pc), 32'(m_pc));
        check("instr", 32'(instr), 32'(m_instr));
        check("instr_valid", 32'(instr_valid), 32'(m_valid));
        check("halted", 32'(halted), 32'(m_halted));
    endtask

    task automatic load(input logic [7:0] a, input logic [8:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        step();
        load_en = 1'b0;
    endtask

    task automatic branch(input logic rel, input logic [7:0] tgt);
        branch_en = 1'b1; branch_rel = rel; branch_target = tgt;
        step();
        branch_en = 1'b0; branch_rel = 1'b0;
    endtask

    function automatic logic [8:0] rnd_word(input bit allow_halt);
        logic [8:0] w;
        w = 9'($urandom_range(0, 510));
        if (allow_halt && $urandom_range(0, 7) == 0) w = Halt;
        return w;
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        stall = 1'b0; branch_en = 1'b0; branch_rel = 1'b0; branch_target = '0;
        m_mode = 0; m_fpc = 0; m_pc = 0; m_instr = 0; m_valid = 0; m_halted = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;

        step();
        step();
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        reset = 1'b0;

        // Known contents everywhere, no halts.
        for (int i = 0; i < 256; i++) load(8'(i), rnd_word(1'b0));

        // Straight-line program ending in a halt.
        load(8'h00, 9'h011); load(8'h01, 9'h022); load(8'h02, 9'h033); load(8'h03, Halt);
        start = 1'b1; step(); start = 1'b0;
        check("seq_bubble", 32'(instr_valid), 32'd0);
        step(); check("seq_i0", 32'(instr), 32'h011); check("seq_pc0", 32'(pc), 32'h00);
        step(); check("seq_i1", 32'(instr), 32'h022); check("seq_pc1", 32'(pc), 32'h01);
        step(); check("seq_i2", 32'(instr), 32'h033); check("seq_pc2", 32'(pc), 32'h02);
        step(); check("seq_ihalt", 32'(instr), 32'h1FF);
        step(); check("seq_halted", 32'(halted), 32'd1);
        check("seq_valid_off", 32'(instr_valid), 32'd0);

        // Absolute branch from pc 1.
        load(8'h03, 9'h044); load(8'h10, 9'h0AB);
        start = 1'b1; step(); start = 1'b0;
        check("restart_halted", 32'(halted), 32'd0);
        step(); step(); check("abs_at_pc1", 32'(pc), 32'h01);
        branch(1'b0, 8'h10); check("abs_bubble", 32'(instr_valid), 32'd0);
        step(); check("abs_pc", 32'(pc), 32'h10); check("abs_instr", 32'(instr), 32'h0AB);
        check("abs_valid", 32'(instr_valid), 32'd1);

        // Relative branches, including a wrap past the top of memory.
        branch(1'b0, 8'h05); step(); check("to_pc5", 32'(pc), 32'h05);
        branch(1'b1, 8'hFE); step(); check("rel_back_pc", 32'(pc), 32'h03);
        check("rel_back_instr", 32'(instr), 32'h044);
        branch(1'b0, 8'hFF); step(); check("to_pcff", 32'(pc), 32'hFF);
        branch(1'b1, 8'h02); step(); check("rel_wrap_pc", 32'(pc), 32'h01);
        check("rel_wrap_instr", 32'(instr), 32'h022);

        // Sequential wrap of the fetch pointer.
        branch(1'b0, 8'hFE);
        step(); check("wrap_fe", 32'(pc), 32'hFE);
        step(); check("wrap_ff", 32'(pc), 32'hFF);
        step(); check("wrap_00", 32'(pc), 32'h00); check("wrap_instr", 32'(instr), 32'h011);

        // Stall holds everything, and defers a pending branch.
        stall = 1'b1; branch_en = 1'b1; branch_target = 8'h20;
        for (int i = 0; i < 3; i++) begin
            step(); check("stall_pc", 32'(pc), 32'h00); check("stall_valid", 32'(instr_valid), 32'd1);
        end
        stall = 1'b0;
        step(); branch_en = 1'b0;
        check("stall_br_bubble", 32'(instr_valid), 32'd0);
        step(); check("stall_br_pc", 32'(pc), 32'h20);

        // Reset mid-run, then restart from address 0 with memory intact.
        step();
        reset = 1'b1; stall = 1'b1; step(); reset = 1'b0; stall = 1'b0;
        check("midrst_pc", 32'(pc), 32'd0); check("midrst_instr", 32'(instr), 32'd0);
        check("midrst_valid", 32'(instr_valid), 32'd0);
        start = 1'b1; step(); start = 1'b0;
        step(); check("rerun_pc", 32'(pc), 32'h00); check("rerun_instr", 32'(instr), 32'h011);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            reset         = ($urandom_range(0, 199) == 0);
            stall         = ($urandom_range(0, 4) == 0);
            branch_en     = ($urandom_range(0, 6) == 0);
            branch_rel    = 1'($urandom_range(0, 1));
            branch_target = 8'($urandom_range(0, 255));
            start         = ($urandom_range(0, 15) == 0);
            load_en       = ($urandom_range(0, 2) == 0);
            load_addr     = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 31))
                                                         : 8'($urandom_range(0, 255));
            load_data     = rnd_word(1'b1);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
